// File: rtl/mca_adder_sequencer.sv
`timescale 1ns/1ps
// mca_adder_sequencer: decimates the in_valid stream, fires start for the multi-cycle adder tree,
// counts down the tree latency and captures its result. Define MCA_SEQ_STATS_EN for the stats counters.
module mca_adder_sequencer #(
  parameter int WIDTH_COEFFICIENT = 32,
  parameter int MCA_NUM_ADDITIONS = 16,
  parameter int NUM_STAGES        = 4,
  parameter int DSR               = 16,
  parameter int LATENCY           = NUM_STAGES * (MCA_NUM_ADDITIONS + 1)
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         enable,
  input  logic                         in_valid,
  input  logic [WIDTH_COEFFICIENT-1:0] tree_sample,
  output logic                         start,
  output logic                         busy,
  output logic [WIDTH_COEFFICIENT-1:0] out_sample,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         overrun,
  input  logic                         clr_overrun,
`ifdef MCA_SEQ_STATS_EN
  output logic [15:0]                  sample_cnt,
  output logic [15:0]                  drop_cnt,
`endif
  output logic                         state_dbg
);

  localparam int DEC_W = $clog2(DSR + 1);
  localparam int CYC_W = $clog2(LATENCY + 1);
  localparam logic [DEC_W-1:0] DEC_MAX  = DEC_W'(DSR - 1);
  localparam logic [CYC_W-1:0] CYC_LOAD = CYC_W'(LATENCY - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e                       state_q, state_d;
  logic [DEC_W-1:0]             dec_cnt_q, dec_cnt_d;
  logic [CYC_W-1:0]             cyc_cnt_q, cyc_cnt_d;
  logic                         start_q, start_d;
  logic [WIDTH_COEFFICIENT-1:0] out_sample_q, out_sample_d;
  logic                         out_valid_q, out_valid_d;
  logic                         overrun_q, overrun_d;
  logic                         trigger, capture, drop, overwrite;

  assign trigger = enable & in_valid & (dec_cnt_q == DEC_MAX);

  // Output handshake: a sample transfers on any clock where out_valid & out_ready;
  // out_sample never changes while out_valid is high except by a new capture.
  always_comb begin
    state_d      = state_q;
    dec_cnt_d    = dec_cnt_q;
    cyc_cnt_d    = cyc_cnt_q;
    start_d      = 1'b0;
    out_sample_d = out_sample_q;
    out_valid_d  = out_valid_q;
    overrun_d    = overrun_q;
    capture      = 1'b0;
    drop         = 1'b0;
    overwrite    = 1'b0;

    if (!enable) begin
      dec_cnt_d = '0;
    end else if (in_valid) begin
      dec_cnt_d = (dec_cnt_q == DEC_MAX) ? '0 : dec_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d   = RUN;
          start_d   = 1'b1;
          cyc_cnt_d = CYC_LOAD;
        end
      end
      RUN: begin
        if (cyc_cnt_q == '0) begin
          capture = 1'b1;
          // A trigger landing on the done cycle chains straight into the next run.
          if (trigger) begin
            start_d   = 1'b1;
            cyc_cnt_d = CYC_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q - 1'b1;
          drop      = trigger;
        end
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      out_sample_d = tree_sample;
      out_valid_d  = 1'b1;
      overwrite    = out_valid_q & ~out_ready;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (clr_overrun) begin
      overrun_d = 1'b0;
    end else if (drop || overwrite) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      dec_cnt_q    <= '0;
      cyc_cnt_q    <= '0;
      start_q      <= 1'b0;
      out_sample_q <= '0;
      out_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      dec_cnt_q    <= dec_cnt_d;
      cyc_cnt_q    <= cyc_cnt_d;
      start_q      <= start_d;
      out_sample_q <= out_sample_d;
      out_valid_q  <= out_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign start      = start_q;
  assign busy       = (state_q == RUN);
  assign out_sample = out_sample_q;
  assign out_valid  = out_valid_q;
  assign overrun    = overrun_q;
  assign state_dbg  = state_q;

`ifdef MCA_SEQ_STATS_EN
  logic [15:0] sample_cnt_q, sample_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    sample_cnt_d = sample_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    if (clr_overrun) begin
      sample_cnt_d = '0;
      drop_cnt_d   = '0;
    end else begin
      if (capture && sample_cnt_q != 16'hFFFF) sample_cnt_d = sample_cnt_q + 16'd1;
      if ((drop || overwrite) && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sample_cnt_q <= '0;
      drop_cnt_q   <= '0;
    end else begin
      sample_cnt_q <= sample_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign sample_cnt = sample_cnt_q;
  assign drop_cnt   = drop_cnt_q;
`endif

endmodule

// File: tb/tb_mca_adder_sequencer.sv
`timescale 1ns/1ps
// Directed bench for mca_adder_sequencer with DSR=4 and the default tree latency of 68 clocks.
module tb_mca_adder_sequencer;
  localparam int W   = 32;
  localparam int DSR = 4;
  localparam int LAT = 68;

  logic         clk = 1'b0;
  logic         resetn, enable, in_valid, out_ready, clr_overrun;
  logic [W-1:0] tree_sample;
  logic         start, busy, out_valid, overrun, state_dbg;
  logic [W-1:0] out_sample;
`ifdef MCA_SEQ_STATS_EN
  logic [15:0]  sample_cnt, drop_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_s;

  mca_adder_sequencer #(.WIDTH_COEFFICIENT(W), .DSR(DSR)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .in_valid(in_valid),
    .tree_sample(tree_sample), .start(start), .busy(busy),
    .out_sample(out_sample), .out_valid(out_valid), .out_ready(out_ready),
    .overrun(overrun), .clr_overrun(clr_overrun),
`ifdef MCA_SEQ_STATS_EN
    .sample_cnt(sample_cnt), .drop_cnt(drop_cnt),
`endif
    .state_dbg(state_dbg)
  );

  // Clock and reset
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks: inputs change on the falling edge, outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    resetn = 1'b0; enable = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    clr_overrun = 1'b0; tree_sample = '0;
    repeat (2) tick();
    resetn = 1'b1;
  endtask

  task automatic pulse_in(input int n);
    in_valid = 1'b1;
    repeat (n) tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (start !== 1'b0) begin failures++; $display("FAIL reset_start: got %b want 0", start); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    checks++; if (out_sample !== '0) begin failures++; $display("FAIL reset_sample: got %h want 0", out_sample); end
    checks++; if (state_dbg !== 1'b0) begin failures++; $display("FAIL reset_state: got %b want 0", state_dbg); end
  endtask

  // in_valid every clock: starts on edges 4, 72, 140; captures on 72 and 140.
  task automatic test_periodic();
    logic es, ev, eb;
    do_reset();
    enable = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    exp_q.push_back(32'hA500_0000 | 32'd72);
    exp_q.push_back(32'hA500_0000 | 32'd140);
    for (int e = 1; e <= 141; e++) begin
      tree_sample = 32'hA500_0000 | W'(e);
      tick();
      es = (e == 4 || e == 72 || e == 140);
      ev = (e == 72 || e == 140);
      eb = (e >= 4);
      checks++; if (start !== es) begin failures++; $display("FAIL periodic_start e=%0d: got %b want %b", e, start, es); end
      checks++; if (out_valid !== ev) begin failures++; $display("FAIL periodic_valid e=%0d: got %b want %b", e, out_valid, ev); end
      checks++; if (busy !== eb) begin failures++; $display("FAIL periodic_busy e=%0d: got %b want %b", e, busy, eb); end
      if (ev && exp_q.size() > 0) begin
        exp_s = exp_q.pop_front();
        checks++; if (out_sample !== exp_s) begin failures++; $display("FAIL periodic_sample e=%0d: got %h want %h", e, out_sample, exp_s); end
      end
    end
    in_valid = 1'b0;
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL periodic_captures: %0d expected samples never seen, want 0", exp_q.size()); end
  endtask

  task automatic test_sign_copy();
    int n;
    do_reset();
    enable = 1'b1; out_ready = 1'b1; tree_sample = 32'hFFFF_FF85;
    pulse_in(DSR);
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin tick(); n++; end
    checks++; if (n != LAT) begin failures++; $display("FAIL sign_latency: got %0d clocks want %0d", n, LAT); end
    checks++; if ($signed(out_sample) !== -32'sd123) begin failures++; $display("FAIL sign_sample: got %0d want -123", $signed(out_sample)); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL sign_overrun: got %b want 0", overrun); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL sign_busy: got %b want 0", busy); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL sign_accept: got %b want 0", out_valid); end
  endtask

  task automatic test_enable_gate();
    do_reset();
    enable = 1'b1;
    pulse_in(3);
    checks++; if (start !== 1'b0) begin failures++; $display("FAIL en_early_start: got %b want 0", start); end
    enable = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; enable = 1'b1;
    pulse_in(3);
    checks++; if (start !== 1'b0) begin failures++; $display("FAIL en_cleared_count: got %b want 0", start); end
    pulse_in(1);
    checks++; if (start !== 1'b1) begin failures++; $display("FAIL en_trigger: got %b want 1", start); end
    enable = 1'b0;
    repeat (LAT - 1) tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL en_run_early: got %b want 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL en_run_completes: got %b want 1", out_valid); end
  endtask

  // Triggers every 4 clocks: edge 8 is dropped, clr on edge 12 beats the drop there.
  task automatic test_drop_overrun();
    logic eo;
    do_reset();
    enable = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      clr_overrun = (e == 12);
      tick();
      if (e == 7 || e == 8 || e == 12 || e == 13 || e == 16) begin
        eo = (e == 8 || e == 16);
        checks++; if (overrun !== eo) begin failures++; $display("FAIL drop_overrun e=%0d: got %b want %b", e, overrun, eo); end
      end
`ifdef MCA_SEQ_STATS_EN
      if (e == 16) begin
        checks++; if (drop_cnt !== 16'd1) begin failures++; $display("FAIL drop_cnt: got %0d want 1", drop_cnt); end
      end
`endif
    end
    clr_overrun = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL drop_busy: got %b want 1", busy); end
    in_valid = 1'b0; clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL drop_clear: got %b want 0", overrun); end
  endtask

  task automatic test_overwrite();
    do_reset();
    enable = 1'b1; tree_sample = 32'h1111_2222;
    pulse_in(DSR);
    repeat (LAT) tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ovw_first_valid: got %b want 1", out_valid); end
    checks++; if (out_sample !== 32'h1111_2222) begin failures++; $display("FAIL ovw_first_sample: got %h want 11112222", out_sample); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovw_first_overrun: got %b want 0", overrun); end
    tree_sample = 32'h3333_4444;
    pulse_in(DSR);
    repeat (LAT - 1) tick();
    checks++; if (out_sample !== 32'h1111_2222) begin failures++; $display("FAIL ovw_stable: got %h want 11112222", out_sample); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovw_pre_overrun: got %b want 0", overrun); end
    tick();
    checks++; if (out_sample !== 32'h3333_4444) begin failures++; $display("FAIL ovw_second_sample: got %h want 33334444", out_sample); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovw_overrun: got %b want 1", overrun); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ovw_second_valid: got %b want 1", out_valid); end
`ifdef MCA_SEQ_STATS_EN
    checks++; if (sample_cnt !== 16'd2) begin failures++; $display("FAIL ovw_sample_cnt: got %0d want 2", sample_cnt); end
    checks++; if (drop_cnt !== 16'd1) begin failures++; $display("FAIL ovw_drop_cnt: got %0d want 1", drop_cnt); end
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ovw_accept: got %b want 0", out_valid); end
  endtask

  // Second trigger lands exactly on the done clock of the first run.
  task automatic test_back_to_back();
    do_reset();
    enable = 1'b1; out_ready = 1'b1; tree_sample = 32'h0BAD_F00D;
    pulse_in(DSR);
    repeat (LAT - DSR) tick();
    pulse_in(DSR);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid: got %b want 1", out_valid); end
    checks++; if (out_sample !== 32'h0BAD_F00D) begin failures++; $display("FAIL b2b_sample: got %h want 0badf00d", out_sample); end
    checks++; if (start !== 1'b1) begin failures++; $display("FAIL b2b_start: got %b want 1", start); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy: got %b want 1", busy); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
    tree_sample = 32'h5A5A_0001;
    repeat (LAT - 1) tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_mid_valid: got %b want 0", out_valid); end
    tick();
    checks++; if (out_sample !== 32'h5A5A_0001) begin failures++; $display("FAIL b2b_second_sample: got %h want 5a5a0001", out_sample); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    enable = 1'b1; tree_sample = 32'hCAFE_0042;
    pulse_in(DSR);
    repeat (LAT) tick();
    pulse_in(DSR);
    pulse_in(DSR);
    repeat (33) tick();
    checks++; if ({busy, out_valid, overrun} !== 3'b111) begin failures++; $display("FAIL rst_mid_pre: got %b want 111", {busy, out_valid, overrun}); end
    resetn = 1'b0;
    #1;
    checks++; if ({start, busy, out_valid, overrun, state_dbg} !== 5'b0) begin failures++; $display("FAIL rst_mid_flags: got %b want 00000", {start, busy, out_valid, overrun, state_dbg}); end
    checks++; if (out_sample !== '0) begin failures++; $display("FAIL rst_mid_sample: got %h want 0", out_sample); end
`ifdef MCA_SEQ_STATS_EN
    checks++; if (sample_cnt !== 16'd0) begin failures++; $display("FAIL rst_mid_sample_cnt: got %0d want 0", sample_cnt); end
`endif
    tick();
    resetn = 1'b1;
    pulse_in(DSR - 1);
    checks++; if (start !== 1'b0) begin failures++; $display("FAIL rst_mid_early_start: got %b want 0", start); end
    repeat (LAT + 2) tick();
    checks++; if ({busy, out_valid} !== 2'b00) begin failures++; $display("FAIL rst_mid_no_capture: got %b want 00", {busy, out_valid}); end
    pulse_in(1);
    checks++; if (start !== 1'b1) begin failures++; $display("FAIL rst_mid_restart: got %b want 1", start); end
  endtask

`ifdef MCA_SEQ_STATS_EN
  // 20 chained runs, each dropping 16 triggers at the 4-clock spacing.
  task automatic test_stats();
    do_reset();
    enable = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    repeat (DSR + 20 * LAT) tick();
    in_valid = 1'b0;
    checks++; if (sample_cnt !== 16'd20) begin failures++; $display("FAIL stats_samples: got %0d want 20", sample_cnt); end
    checks++; if (drop_cnt !== 16'd320) begin failures++; $display("FAIL stats_drops: got %0d want 320", drop_cnt); end
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    checks++; if ({sample_cnt, drop_cnt} !== 32'd0) begin failures++; $display("FAIL stats_clear: got %h want 0", {sample_cnt, drop_cnt}); end
  endtask
`endif

  initial begin
    test_reset();
    test_periodic();
    test_sign_copy();
    test_enable_gate();
    test_drop_overrun();
    test_overwrite();
    test_back_to_back();
    test_reset_mid_run();
`ifdef MCA_SEQ_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
